// File: rtl/bit_wise_pkg.sv
// Shared types and defaults for the BitWise operand feeder.
package bit_wise_pkg;

    localparam int unsigned BIT_WISE_N = 32;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CAPTURE
    } bit_wise_feeder_state_t;

endpackage

// File: rtl/bit_wise_operand_fifo.sv
// Operand-pair FIFO: 2N-bit entries, DEPTH deep, head visible combinationally on rdata.
module bit_wise_operand_fifo #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [2*N-1:0]               wdata,
    input  logic                         pop,
    output logic [2*N-1:0]               rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [2*N-1:0] mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bit_wise_operand_feeder.sv
// Buffers operand pairs and applies them to the BitWise unit with a fixed
// settle window, strobing capture when the unit's output may be sampled.
module bit_wise_operand_feeder
    import bit_wise_pkg::*;
#(
    parameter int unsigned N      = BIT_WISE_N,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N-1:0]                 in_a,
    input  logic [N-1:0]                 in_b,
    output logic [N-1:0]                 a,
    output logic [N-1:0]                 b,
    output logic                         capture,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    bit_wise_feeder_state_t state;
    bit_wise_feeder_state_t state_next;
    logic [SW-1:0]          settle_cnt;
    logic [SW-1:0]          settle_next;
    logic                   pop;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [2*N-1:0]         head;

    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready;

    bit_wise_operand_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_a, in_b}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    // Next-state, settle countdown and pop decision.
    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    settle_next = SW'(SETTLE - 1);
                    state_next  = APPLY;
                end
            end
            APPLY: begin
                if (settle_cnt == '0) begin
                    state_next = CAPTURE;
                end else begin
                    settle_next = settle_cnt - SW'(1);
                end
            end
            CAPTURE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    settle_next = SW'(SETTLE - 1);
                    state_next  = APPLY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // capture/busy are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            a          <= '0;
            b          <= '0;
            capture    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_next;
            capture    <= (state_next == CAPTURE);
            busy       <= (state_next != IDLE);
            if (pop) begin
                a <= head[2*N-1:N];
                b <= head[N-1:0];
            end
        end
    end

endmodule
